// File: rtl/pll_md_sequencer.sv
// pll_md_sequencer: writes a shadow buffer into PLL registers over the dynamic-reconfiguration
// port, reads it back to verify, pulses pll_rst and waits for lock.
// Ports: mdclk/reset clock and async reset; wr_en/wr_idx/wr_data shadow load (idle only);
// cfg_addr/cfg_len/start sequence request; mdopc/mdainc/mdwdi/mdrdo reconfiguration bus;
// pll_rst/pll_lock PLL control; busy/done/err/locked status.
module pll_md_sequencer #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic       mdclk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [2:0] wr_idx,
    input  logic [7:0] wr_data,
    input  logic [7:0] cfg_addr,
    input  logic [3:0] cfg_len,
    input  logic       start,
    output logic [1:0] mdopc,
    output logic       mdainc,
    output logic [7:0] mdwdi,
    input  logic [7:0] mdrdo,
    output logic       pll_rst,
    input  logic       pll_lock,
    output logic       busy,
    output logic       done,
    output logic [1:0] err,
    output logic       locked
);
    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_SET_WA = 4'd1;
    localparam logic [3:0] S_WRITE  = 4'd2;
    localparam logic [3:0] S_SET_RA = 4'd3;
    localparam logic [3:0] S_READ   = 4'd4;
    localparam logic [3:0] S_CMP    = 4'd5;
    localparam logic [3:0] S_PRST   = 4'd6;
    localparam logic [3:0] S_WLOCK  = 4'd7;
    localparam logic [3:0] S_DONE   = 4'd8;

    logic [3:0]  r_state;
    logic [1:0]  r_sync;
    logic [7:0]  r_shadow [8];
    logic [7:0]  r_addr;
    logic [3:0]  r_len;
    logic [2:0]  r_idx;
    logic [15:0] r_cnt;
    logic [1:0]  r_err;
    logic [3:0]  w_len;
    logic        w_last;

    assign w_len  = (cfg_len > 4'd8) ? 4'd8 : cfg_len;
    assign w_last = ({1'b0, r_idx} == r_len - 4'd1);

    always_ff @(posedge mdclk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_sync  <= 2'b00;
            r_addr  <= 8'd0;
            r_len   <= 4'd0;
            r_idx   <= 3'd0;
            r_cnt   <= 16'd0;
            r_err   <= 2'b00;
            for (int i = 0; i < 8; i++) r_shadow[i] <= 8'd0;
        end else begin
            r_sync <= {r_sync[0], pll_lock};
            if (wr_en && r_state == S_IDLE) r_shadow[wr_idx] <= wr_data;
            case (r_state)
                S_IDLE: if (start) begin
                    r_addr  <= cfg_addr;
                    r_len   <= w_len;
                    r_err   <= 2'b00;
                    r_idx   <= 3'd0;
                    r_cnt   <= 16'd0;
                    r_state <= (w_len == 4'd0) ? S_PRST : S_SET_WA;
                end
                S_SET_WA: r_state <= S_WRITE;
                S_WRITE: begin
                    r_idx <= w_last ? 3'd0 : r_idx + 3'd1;
                    if (w_last) r_state <= S_SET_RA;
                end
                S_SET_RA: r_state <= S_READ;
                S_READ:   r_state <= S_CMP;
                S_CMP: if (mdrdo != r_shadow[r_idx]) begin
                    r_err[0] <= 1'b1;
                    r_state  <= S_DONE;
                end else if (w_last) begin
                    r_cnt   <= 16'd0;
                    r_state <= S_PRST;
                end else begin
                    r_idx   <= r_idx + 3'd1;
                    r_state <= S_READ;
                end
                S_PRST: if (r_cnt == 16'(RST_CYCLES - 1)) begin
                    r_cnt   <= 16'd0;
                    r_state <= S_WLOCK;
                end else r_cnt <= r_cnt + 16'd1;
                // lock is checked before the timeout so a same-cycle lock wins
                S_WLOCK: if (r_sync[1]) r_state <= S_DONE;
                else if (r_cnt == 16'(LOCK_TIMEOUT - 1)) begin
                    r_err[1] <= 1'b1;
                    r_state  <= S_DONE;
                end else r_cnt <= r_cnt + 16'd1;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // outputs decode from state only, so reset clears the bus without waiting for a clock
    always_comb begin
        mdopc   = (r_state == S_SET_WA || r_state == S_SET_RA) ? 2'b01 :
                  (r_state == S_WRITE) ? 2'b10 : (r_state == S_READ) ? 2'b11 : 2'b00;
        mdainc  = (r_state == S_WRITE || r_state == S_READ);
        mdwdi   = (r_state == S_SET_WA || r_state == S_SET_RA) ? r_addr :
                  (r_state == S_WRITE) ? r_shadow[r_idx] : 8'd0;
        pll_rst = (r_state == S_PRST);
        busy    = (r_state != S_IDLE);
        done    = (r_state == S_DONE);
        err     = r_err;
        locked  = r_sync[1] & (r_state == S_IDLE);
    end
endmodule
